// File: rtl/mips_load_store_unit_pkg.sv
// mips_load_store_unit_pkg: opcodes, memory-port opcodes and FSM states shared by the load/store unit.
package mips_load_store_unit_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;
  localparam logic [5:0] OP_LB = 6'b100000;
  localparam logic [5:0] OP_LH = 6'b100001;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB = 6'b101000;
  localparam logic [5:0] OP_SH = 6'b101001;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] MEM_OP_READ = 6'b100011;
  localparam logic [5:0] MEM_OP_WRITE = 6'b101011;
  function automatic logic legal_op(input logic [5:0] op);
    return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
  endfunction
endpackage

// File: rtl/mips_load_store_unit_align.sv
// mips_load_store_unit_align: big-endian lane extraction/extension, store merge and misalign detect.
module mips_load_store_unit_align (
  input  logic [5:0]  opcode,
  input  logic [1:0]  lane,
  input  logic [31:0] read_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_value,
  output logic [31:0] store_word,
  output logic        misalign
);
  logic [4:0] bsh, hsh;
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] mask, ins;
  // opcode[1:0] is the access size (00 byte, 01 half, 11 word); opcode[2] marks unsigned loads
  always_comb begin
    bsh = {~lane, 3'b000};
    hsh = {~lane[1], 4'b0000};
    b = 8'(read_word >> bsh);
    h = 16'(read_word >> hsh);
    load_value = opcode[1:0] == 2'b00 ? {{24{b[7] & ~opcode[2]}}, b} :
                 opcode[1:0] == 2'b01 ? {{16{h[15] & ~opcode[2]}}, h} : read_word;
    mask = opcode[1:0] == 2'b00 ? 32'hFF << bsh : opcode[1:0] == 2'b01 ? 32'hFFFF << hsh : '1;
    ins = opcode[1:0] == 2'b00 ? {24'b0, store_data[7:0]} << bsh :
          opcode[1:0] == 2'b01 ? {16'b0, store_data[15:0]} << hsh : store_data;
    store_word = (read_word & ~mask) | ins;
    misalign = opcode[1:0] == 2'b01 ? lane[0] : opcode[1:0] == 2'b11 ? |lane : 1'b0;
  end
endmodule

// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: one-at-a-time load/store FSM driving a combinational-read data memory.
module mips_load_store_unit
  import mips_load_store_unit_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_address,
  input  logic [31:0] req_store_data,
  input  logic [4:0]  req_rt,
  output logic        resp_valid,
  output logic [31:0] resp_load_data,
  output logic [4:0]  resp_rt,
  output logic        resp_exception,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic [5:0]  mem_opcode,
  output logic        signal_mem_read,
  output logic        signal_mem_write,
  input  logic [31:0] mem_read_data
);
  state_t state;
  logic [5:0] op;
  logic [31:0] addr, data;
  logic [4:0] rt;
  logic exc, misalign, bad;
  logic [31:0] load_value, store_word;
  // data holds store data until READ, then the extended load value or the merged store word
  mips_load_store_unit_align align (
    .opcode(state == IDLE ? req_opcode : op),
    .lane(state == IDLE ? req_address[1:0] : addr[1:0]),
    .read_word(mem_read_data),
    .store_data(data),
    .load_value(load_value),
    .store_word(store_word),
    .misalign(misalign)
  );
  assign bad = !legal_op(req_opcode) || (CHECK_ALIGN != 0 && misalign);
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      addr <= '0;
      data <= '0;
      rt <= '0;
      exc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op <= req_opcode;
          addr <= req_address;
          data <= req_store_data;
          rt <= req_rt;
          exc <= bad;
          state <= bad ? RESP : req_opcode == OP_SW ? WRITE : READ;
        end
        READ: begin
          data <= op[3] ? store_word : load_value;
          state <= op[3] ? WRITE : RESP;
        end
        WRITE: state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end
  assign req_ready = state == IDLE;
  assign resp_valid = state == RESP;
  assign resp_load_data = resp_valid && !exc && !op[3] ? data : '0;
  assign resp_rt = resp_valid ? rt : '0;
  assign resp_exception = resp_valid && exc;
  assign signal_mem_read = state == READ;
  assign signal_mem_write = state == WRITE;
  assign mem_address = signal_mem_read || signal_mem_write ? {addr[31:2], 2'b00} : '0;
  assign mem_data_in = signal_mem_write ? data : '0;
  assign mem_opcode = signal_mem_read ? MEM_OP_READ : signal_mem_write ? MEM_OP_WRITE : 6'b000000;
endmodule

// File: tb/tb_mips_load_store_unit.sv
// tb_mips_load_store_unit: directed and random requests against a byte-array memory reference model.
module tb_mips_load_store_unit;
  localparam logic [5:0] LB = 6'b100000, LH = 6'b100001, LW = 6'b100011, LBU = 6'b100100;
  localparam logic [5:0] LHU = 6'b100101, SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
  logic clk = 0, reset = 1, req_valid = 0;
  logic req_ready, resp_valid, resp_exception, signal_mem_read, signal_mem_write;
  logic [5:0] req_opcode = 0, mem_opcode;
  logic [31:0] req_address = 0, req_store_data = 0, resp_load_data, mem_address, mem_data_in, mem_read_data;
  logic [4:0] req_rt = 0, resp_rt;
  logic [31:0] dmem [16];
  logic [7:0] rb [64];
  int vectors = 0, errors = 0;

  mips_load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_address(req_address), .req_store_data(req_store_data),
    .req_rt(req_rt), .resp_valid(resp_valid), .resp_load_data(resp_load_data),
    .resp_rt(resp_rt), .resp_exception(resp_exception), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_opcode(mem_opcode), .signal_mem_read(signal_mem_read),
    .signal_mem_write(signal_mem_write), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;
  assign mem_read_data = dmem[mem_address[5:2]];
  always @(posedge clk) if (signal_mem_write) dmem[mem_address[5:2]] <= mem_data_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int w;
    w = a & ~3;
    return {rb[w], rb[w + 1], rb[w + 2], rb[w + 3]};
  endfunction

  function automatic int size_of(input logic [5:0] op);
    return (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
  endfunction

  // Issue one request and check every cycle until its response.
  task automatic do_req(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rt);
    int size, b, nc;
    logic legal, store, exc, rd, wr, rv;
    logic [31:0] v, ww;
    size = size_of(op);
    b = int'(a[5:0]);
    legal = op inside {LB, LH, LW, LBU, LHU, SB, SH, SW};
    store = legal && op[3];
    exc = !legal || (int'(a[1:0]) % size != 0);
    v = 0;
    if (!exc && !store) begin
      for (int i = 0; i < size; i++) v = {v[23:0], rb[b + i]};
      if (op == LB) v = {{24{v[7]}}, v[7:0]};
      if (op == LH) v = {{16{v[15]}}, v[15:0]};
    end
    if (!exc && store)
      for (int i = 0; i < size; i++) rb[b + i] = 8'(sd >> (8 * (size - 1 - i)));
    ww = ref_word(b);
    nc = exc ? 1 : (store && size < 4) ? 3 : 2;
    @(negedge clk);
    req_valid = 1; req_opcode = op; req_address = a; req_store_data = sd; req_rt = rt;
    chk("ready_idle", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 0;
    for (int c = 1; c <= nc; c++) begin
      @(negedge clk);
      rd = !exc && !(store && size == 4) && c == 1;
      wr = !exc && store && c == nc - 1;
      rv = c == nc;
      chk("ready_busy", {31'b0, req_ready}, 0);
      chk("mem_read", {31'b0, signal_mem_read}, {31'b0, rd});
      chk("mem_write", {31'b0, signal_mem_write}, {31'b0, wr});
      chk("resp_valid", {31'b0, resp_valid}, {31'b0, rv});
      chk("mem_opcode", {26'b0, mem_opcode}, rd ? 32'h23 : wr ? 32'h2B : 32'h0);
      chk("mem_address", mem_address, rd || wr ? {a[31:2], 2'b00} : 32'h0);
      if (wr) chk("mem_data_in", mem_data_in, ww);
      if (rv) begin
        chk("resp_data", resp_load_data, v);
        chk("resp_rt", {27'b0, resp_rt}, {27'b0, rt});
        chk("resp_exc", {31'b0, resp_exception}, {31'b0, exc});
      end
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [31:0] a, d;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 0);
    chk("rst_strobes", {30'b0, signal_mem_read, signal_mem_write}, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_opcode", {26'b0, mem_opcode}, 0);
    chk("rst_resp_data", resp_load_data, 0);
    for (int w = 0; w < 16; w++) do_req(SW, 32'(w * 4), $urandom, 5'(w));
    do_req(SW, 32'h4, 32'h11223344, 0);
    do_req(LW, 32'h4, 0, 5'd9);
    chk("lw_model", ref_word(4), 32'h11223344);
    do_req(SW, 32'h4, 32'h80FF7F01, 0);
    do_req(LB, 32'h4, 0, 5'd1);
    do_req(LBU, 32'h4, 0, 5'd2);
    do_req(LH, 32'h6, 0, 5'd3);
    do_req(LH, 32'h4, 0, 5'd4);
    do_req(SW, 32'h4, 32'h11223344, 0);
    do_req(SH, 32'h6, 32'hAAAABBBB, 5'd5);
    chk("sh_merged", ref_word(4), 32'h1122BBBB);
    do_req(LW, 32'h6, 0, 5'd6);
    do_req(6'b000000, 32'h4, 0, 5'd7);
    // reset while an sb sits in READ: the write must never happen
    @(negedge clk);
    req_valid = 1; req_opcode = SB; req_address = 32'h8; req_store_data = 32'h5A; req_rt = 5'd8;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("abort_read", {31'b0, signal_mem_read}, 1);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("abort_write", {31'b0, signal_mem_write}, 0);
    chk("abort_resp", {31'b0, resp_valid}, 0);
    chk("abort_ready", {31'b0, req_ready}, 1);
    @(negedge clk);
    chk("abort_resp2", {31'b0, resp_valid}, 0);
    chk("abort_mem", dmem[2], ref_word(8));
    // back-to-back with req_valid held high
    d = $urandom;
    for (int i = 0; i < 4; i++) rb[16 + i] = 8'(d >> (24 - 8 * i));
    @(negedge clk);
    req_valid = 1; req_opcode = SW; req_address = 32'h10; req_store_data = d; req_rt = 5'd3;
    chk("b2b_ready0", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 req_opcode = LW; req_store_data = 0; req_rt = 5'd4;
    @(negedge clk);
    chk("b2b_c1_ready", {31'b0, req_ready}, 0);
    chk("b2b_c1_write", {31'b0, signal_mem_write}, 1);
    @(negedge clk);
    chk("b2b_c2_ready", {31'b0, req_ready}, 0);
    chk("b2b_c2_resp", {31'b0, resp_valid}, 1);
    @(negedge clk);
    chk("b2b_c3_ready", {31'b0, req_ready}, 1);
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    chk("b2b_c4_read", {31'b0, signal_mem_read}, 1);
    @(negedge clk);
    chk("b2b_c5_resp", {31'b0, resp_valid}, 1);
    chk("b2b_c5_data", resp_load_data, d);
    chk("b2b_c5_rt", {27'b0, resp_rt}, 4);
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 8))
        0: op = LB; 1: op = LH; 2: op = LW; 3: op = LBU; 4: op = LHU;
        5: op = SB; 6: op = SH; 7: op = SW;
        default: op = 6'($urandom);
      endcase
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = size_of(op) == 4 ? 2'b00 : size_of(op) == 2 ? {a[1], 1'b0} : a[1:0];
      do_req(op, a, $urandom, 5'($urandom));
    end
    for (int w = 0; w < 16; w++) chk("final_mem", dmem[w], ref_word(w * 4));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
